// File: rtl/ir_prefetch_queue_if.sv
// ----------------------------------------------------------------------------
// ir_prefetch_queue_if
// Bundles the fetch-side offer, the decode-side handshake and the decoded head
// fields of the instruction prefetch queue.
//   slave  modport : the queue itself (consumes offers, drives head/decode)
//   master modport : the surrounding fetch/decode logic (or a testbench)
// Signals:
//   flush                      synchronous queue clear
//   in_valid / in_instr        instruction offered by fetch
//   in_ready                   queue can accept an instruction
//   out_valid / out_ready      decode-side handshake
//   out_instr                  head instruction
//   sub_instr, dr, sa, sb      head fields
//   imm                        sign-extended immediate of the head
//   count                      current occupancy
// ----------------------------------------------------------------------------
interface ir_prefetch_queue_if #(
  parameter int IW    = 16,
  parameter int RW    = 4,
  parameter int OPW   = 8,
  parameter int DEPTH = 4
);
  logic                       flush;
  logic                       in_valid;
  logic [IW-1:0]              in_instr;
  logic                       in_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [IW-1:0]              out_instr;
  logic [OPW-1:0]             sub_instr;
  logic [RW-1:0]              dr;
  logic [RW-1:0]              sa;
  logic [RW-1:0]              sb;
  logic [IW-1:0]              imm;
  logic [$clog2(DEPTH):0]     count;

  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, sub_instr, dr, sa, sb, imm, count
  );

  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, sub_instr, dr, sa, sb, imm, count
  );
endinterface

// File: rtl/ir_prefetch_queue.sv
// ----------------------------------------------------------------------------
// ir_prefetch_queue
// DEPTH-entry instruction FIFO between fetch and decode. The head entry is
// decoded combinationally into opcode, register indices and a sign-extended
// immediate. There is no empty bypass and no full pass-through: a pushed word
// becomes visible one cycle after its push edge, and in_ready depends only on
// the registered occupancy.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (release synchronous to clk upstream)
//   bus    ir_prefetch_queue_if.slave (see interface header for signals)
// ----------------------------------------------------------------------------
module ir_prefetch_queue #(
  parameter int IW    = 16,
  parameter int RW    = 4,
  parameter int OPW   = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ir_prefetch_queue_if.slave    bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Storage is deliberately not reset; the out_valid masking hides stale data.
  logic [IW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_r;

  logic          in_ready_w;
  logic          out_valid_w;
  logic          push;
  logic          pop;
  logic [IW-1:0] head;

  function automatic logic signed [IW-1:0] sext_imm(input logic [2*RW-1:0] v);
    return {{(IW-2*RW){v[2*RW-1]}}, v};
  endfunction

  assign in_ready_w  = (count_r < DEPTH_C);
  assign out_valid_w = (count_r != '0);

  // flush wins over both handshakes on the same edge.
  assign push = bus.in_valid  & in_ready_w  & ~bus.flush;
  assign pop  = bus.out_ready & out_valid_w & ~bus.flush;

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Data storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_instr;
  end

  assign head = mem[rd_ptr];

  // Head decode; everything reads zero while the queue is empty so that
  // uninitialised or already-popped entries never leak out.
  always_comb begin
    bus.out_instr = '0;
    bus.sub_instr = '0;
    bus.dr        = '0;
    bus.sa        = '0;
    bus.sb        = '0;
    bus.imm       = '0;
    if (out_valid_w) begin
      bus.out_instr = head;
      bus.sub_instr = head[IW-1:IW-OPW];
      bus.dr        = head[3*RW-1:2*RW];
      bus.sa        = head[2*RW-1:RW];
      bus.sb        = head[RW-1:0];
      bus.imm       = sext_imm(head[2*RW-1:0]);
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.count     = count_r;

endmodule
